e_muldiv_sequencer: RTL and testbench
=====================================

Name: e_muldiv_sequencer

Overview:
- Multi-cycle multiply/divide unit and its sequencer for the E stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers and runs MULT/MULTU/DIV/DIVU for a fixed number of cycles.
- Executes MTHI/MTLO and serves MFHI/MFLO.
- Generates the D-stage stall request that holds any HI/LO-related instruction while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy duration of MULT/MULTU in cycles (>=1)
- DIV_CYCLES, 10, busy duration of DIV/DIVU in cycles (>=1)

Ports:
- clk  input  1  system clock, rising-edge
- reset_n  input  1  asynchronous, active-low reset
- e_md_valid  input  1  E-stage instruction is a mul/div-class instruction (qualified, not bubbled)
- e_md_op  input  3  MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5, MD_MFHI=6, MD_MFLO=7
- e_rs_data  input  32  forwarded rs operand
- e_rt_data  input  32  forwarded rt operand
- d_is_md  input  1  D-stage instruction is any of the eight md ops (from decode)
- md_rdata  output  32  HI (MFHI) or LO (MFLO), combinational from current registers; 0 otherwise
- busy  output  1  operation in flight
- stall_d  output  1  freeze PC/F/D and bubble E
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (async, reset_n=0): state=IDLE, cnt=0, hi=0, lo=0, pending results=0, busy=0. stall_d is combinational and follows busy/inputs.
- Start condition: start = e_md_valid & (op in {MULT,MULTU,DIV,DIVU}) & state==IDLE.
- States:
  - IDLE -> RUN on start. Operands are latched and cnt = MULT_CYCLES or DIV_CYCLES.
  - RUN: cnt decrements each edge. At the edge where cnt==1, pending results commit to hi/lo, state -> IDLE, cnt -> 0.
- Latency: start sampled at edge k; busy=1 for cycles after edges k..k+N-1; hi/lo show new values after edge k+N. An MFHI/MFLO stalled behind the operation therefore reads the committed value.
- Arithmetic:
  - MULT: signed 32x32 -> 64; MULTU: unsigned. hi=[63:32], lo=[31:0].
  - DIV: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend (rs / rt).
  - DIVU: unsigned.
  - Divisor 0: busy runs the full DIV_CYCLES, but hi/lo are left unchanged at commit.
  - Results may be computed at start and held in pending registers; only the commit time is architectural.
- MTHI/MTLO: when e_md_valid in IDLE, hi (resp. lo) <= e_rs_data at the next edge. They never start RUN.
- stall_d = d_is_md & (busy | start). A D-stage md op behind a starting mult/div is held from the same cycle.
- e_md_valid with a mult/div/MT op while busy: ignored; state, hi and lo are unchanged. The pipeline guarantees this cannot occur, and verification flags it as an assertion.
- Simultaneous commit edge and a new e_md_valid start: cannot occur, because stall_d holds it in D until busy=0. If forced, the start is ignored because state!=IDLE at that edge.
- reset_n asserted mid-RUN: immediate abort. hi/lo=0, busy=0; the pending result is discarded.

Decomposition:
- Shared package/header: MD_* op encodings; state encodings MD_IDLE/MD_RUN.
- Decoding md ops into e_md_op and d_is_md belongs in the general controller, next to its existing per-instruction decode wires.
- One natural sub-module: md_arith, a purely combinational 64-bit product/quotient/remainder with a signed/unsigned select. The sequencer holds the FSM, counter, pending registers and HI/LO.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> hi=lo=0, busy=0. Release reset, then MTHI rs=0x12345678 -> hi=0x12345678 at the next edge, busy stays 0.
- MULT rs=0xFFFFFFFE(-2), rt=3 -> busy for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> busy for 10 cycles; then lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1). DIVU rs=7, rt=2 -> lo=3, hi=1.
- Stall: DIV issued with MFLO immediately behind it in D -> stall_d=1 from the start cycle through all 10 busy cycles, 0 after. md_rdata on MFLO in E equals the committed quotient.
- Divide by zero: preload hi=0xAAAA0000, lo=0x0000BBBB; DIV rt=0 -> busy for 10 cycles, then hi/lo unchanged.
- Reset mid-RUN: drop reset_n asynchronously at cycle 3 of a MULT -> busy=0, hi=lo=0 immediately, with no commit on any later edge.

Source files
------------

// File: rtl/e_muldiv_sequencer_pkg.sv
// Shared types for the E-stage multiply/divide sequencer: op encodings,
// FSM states and the HI/LO result pair.
package e_muldiv_sequencer_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MFHI  = 3'd6,
    MD_MFLO  = 3'd7
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } md_pair_t;

  // Ops that occupy the unit for multiple cycles
  function automatic logic is_muldiv(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_muldiv_sequencer_if.sv
// E-stage <-> mul/div unit bus: instruction issue, D-stage hazard input,
// HI/LO read data and stall/busy status.
interface e_muldiv_sequencer_if;
  import e_muldiv_sequencer_pkg::*;

  logic            e_md_valid;
  md_op_e          e_md_op;
  logic [XLEN-1:0] e_rs_data;
  logic [XLEN-1:0] e_rt_data;
  logic            d_is_md;
  logic [XLEN-1:0] md_rdata;
  logic            busy;
  logic            stall_d;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output e_md_valid, e_md_op, e_rs_data, e_rt_data, d_is_md,
    input  md_rdata, busy, stall_d, hi, lo
  );

  modport slave (
    input  e_md_valid, e_md_op, e_rs_data, e_rt_data, d_is_md,
    output md_rdata, busy, stall_d, hi, lo
  );

endinterface

// File: rtl/e_muldiv_sequencer_md_arith.sv
// Combinational 32x32 multiply and divide with signed/unsigned select.
// Division is done on magnitudes, then signs are restored (truncating toward zero).
module e_muldiv_sequencer_md_arith
  import e_muldiv_sequencer_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            is_signed,
  output md_pair_t        prod,
  output md_pair_t        divr,
  output logic            div_zero
);

  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] b_ext;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN-1:0]   q_mag;
  logic [XLEN-1:0]   r_mag;

  always_comb begin
    a_ext = is_signed ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    b_ext = is_signed ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    prod  = md_pair_t'(a_ext * b_ext);

    a_neg    = is_signed & a[XLEN-1];
    b_neg    = is_signed & b[XLEN-1];
    a_mag    = a_neg ? XLEN'(-a) : a;
    b_mag    = b_neg ? XLEN'(-b) : b;
    div_zero = (b == '0);
    // Guard keeps the divider output defined when the divisor is zero
    q_mag    = div_zero ? '0 : a_mag / b_mag;
    r_mag    = div_zero ? '0 : a_mag % b_mag;
    divr.lo  = (a_neg ^ b_neg) ? XLEN'(-q_mag) : q_mag;
    divr.hi  = a_neg ? XLEN'(-r_mag) : r_mag;
  end

endmodule

// File: rtl/e_muldiv_sequencer.sv
// E-stage multiply/divide sequencer: owns HI/LO, runs MULT/DIV for a fixed
// cycle count, serves MT/MF ops and raises the D-stage stall.
module e_muldiv_sequencer
  import e_muldiv_sequencer_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  e_muldiv_sequencer_if.slave   md
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_pair_t        pend_q, pend_d;
  logic            pend_wr_q, pend_wr_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;

  logic            op_is_div;
  logic            op_is_signed;
  logic            start;
  md_pair_t        prod;
  md_pair_t        divr;
  logic            div_zero;

  assign op_is_div    = (md.e_md_op == MD_DIV) || (md.e_md_op == MD_DIVU);
  assign op_is_signed = (md.e_md_op == MD_MULT) || (md.e_md_op == MD_DIV);
  assign start        = md.e_md_valid & is_muldiv(md.e_md_op) & (state_q == MD_IDLE);

  e_muldiv_sequencer_md_arith u_arith (
    .a         (md.e_rs_data),
    .b         (md.e_rt_data),
    .is_signed (op_is_signed),
    .prod      (prod),
    .divr      (divr),
    .div_zero  (div_zero)
  );

  // State and architectural registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Next state: results are computed at start and only committed on the last busy edge
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d   = MD_RUN;
          cnt_d     = op_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          pend_d    = op_is_div ? divr : prod;
          pend_wr_d = ~(op_is_div & div_zero);
        end else if (md.e_md_valid && md.e_md_op == MD_MTHI) begin
          hi_d = md.e_rs_data;
        end else if (md.e_md_valid && md.e_md_op == MD_MTLO) begin
          lo_d = md.e_rs_data;
        end
      end
      MD_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
          if (pend_wr_q) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
        end
      end
    endcase
  end

  // MFHI/MFLO read path and hazard stall
  always_comb begin
    md.md_rdata = '0;
    if (md.e_md_valid && md.e_md_op == MD_MFHI) begin
      md.md_rdata = hi_q;
    end else if (md.e_md_valid && md.e_md_op == MD_MFLO) begin
      md.md_rdata = lo_q;
    end
  end

  assign md.busy    = (state_q == MD_RUN);
  assign md.stall_d = md.d_is_md & (md.busy | start);
  assign md.hi      = hi_q;
  assign md.lo      = lo_q;

endmodule

// File: tb/tb_e_muldiv_sequencer.sv
// Directed bench for the mul/div sequencer: an arithmetic reference model is
// compared against the DUT every cycle, plus literal spot checks.
module tb_e_muldiv_sequencer;
  import e_muldiv_sequencer_pkg::*;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;
  logic chk_en;

  e_muldiv_sequencer_if bus ();

  e_muldiv_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .md      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining busy cycles and the result to commit at the end
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_left;
  logic        m_wr;
  logic [63:0] m_p;
  int          m_sa, m_sb;
  int unsigned m_ua, m_ub;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_wr = 0;
    end else if (m_left > 0) begin
      if (m_left == 1 && m_wr) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
      m_left--;
    end else if (bus.e_md_valid) begin
      m_sa = $signed(bus.e_rs_data);
      m_sb = $signed(bus.e_rt_data);
      m_ua = bus.e_rs_data;
      m_ub = bus.e_rt_data;
      case (bus.e_md_op)
        MD_MULT: begin
          m_p = longint'(m_sa) * longint'(m_sb);
          m_phi = m_p[63:32]; m_plo = m_p[31:0]; m_wr = 1; m_left = 5;
        end
        MD_MULTU: begin
          m_p = longint'(m_ua) * longint'(m_ub);
          m_phi = m_p[63:32]; m_plo = m_p[31:0]; m_wr = 1; m_left = 5;
        end
        MD_DIV: begin
          m_wr = (m_sb != 0);
          if (m_sb != 0) begin m_plo = m_sa / m_sb; m_phi = m_sa % m_sb; end
          m_left = 10;
        end
        MD_DIVU: begin
          m_wr = (m_ub != 0);
          if (m_ub != 0) begin m_plo = m_ua / m_ub; m_phi = m_ua % m_ub; end
          m_left = 10;
        end
        MD_MTHI: m_hi = bus.e_rs_data;
        MD_MTLO: m_lo = bus.e_rs_data;
        default: ;
      endcase
    end
  end

  logic        e_busy, e_start;
  logic [31:0] e_rdata;

  always @(negedge clk) begin
    if (chk_en) begin
      e_busy  = (m_left > 0);
      e_start = bus.e_md_valid && (bus.e_md_op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}) && !e_busy;
      e_rdata = 0;
      if (bus.e_md_valid && bus.e_md_op == MD_MFHI) e_rdata = m_hi;
      if (bus.e_md_valid && bus.e_md_op == MD_MFLO) e_rdata = m_lo;
      chk("cyc_busy", 32'(bus.busy), 32'(e_busy));
      chk("cyc_stall_d", 32'(bus.stall_d), 32'(bus.d_is_md & (e_busy | e_start)));
      chk("cyc_hi", bus.hi, m_hi);
      chk("cyc_lo", bus.lo, m_lo);
      chk("cyc_md_rdata", bus.md_rdata, e_rdata);
    end
  end

  // Present one E-stage instruction for one cycle, then bubble E
  task automatic drive(input logic v, input md_op_e op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic d);
    bus.e_md_valid = v;
    bus.e_md_op    = op;
    bus.e_rs_data  = rs;
    bus.e_rt_data  = rt;
    bus.d_is_md    = d;
    @(posedge clk); #1;
    bus.e_md_valid = 1'b0;
  endtask

  // Idle E until busy drops (bounded); n = busy cycles seen
  task automatic wait_idle(input logic d, output int n);
    n = 0;
    while (bus.busy && n < 50) begin
      n++;
      drive(1'b0, MD_MFLO, 32'h0, 32'h0, d);
    end
  endtask

  int nb;

  initial begin
    n_tests = 0; n_fail = 0; chk_en = 0;
    bus.e_md_valid = 0; bus.e_md_op = MD_MULT; bus.e_rs_data = 0;
    bus.e_rt_data = 0; bus.d_is_md = 0;
    reset_n = 1;
    #1 reset_n = 0;
    #1 chk_en = 1;

    // Reset held with random inputs
    repeat (4) begin
      bus.e_md_valid = 1'($urandom_range(0, 1));
      bus.e_md_op    = md_op_e'(3'($urandom_range(0, 7)));
      bus.e_rs_data  = $urandom;
      bus.e_rt_data  = $urandom;
      bus.d_is_md    = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    bus.e_md_valid = 0; bus.d_is_md = 0;
    reset_n = 1;
    drive(1'b0, MD_MFHI, 0, 0, 1'b0);

    drive(1'b1, MD_MTHI, 32'h12345678, 0, 1'b0);
    chk("mthi_hi", bus.hi, 32'h12345678);
    chk("mthi_busy", 32'(bus.busy), 32'h0);

    drive(1'b1, MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
    wait_idle(1'b0, nb);
    chk("mult_cycles", 32'(nb), 32'd5);
    chk("mult_hi", bus.hi, 32'hFFFFFFFF);
    chk("mult_lo", bus.lo, 32'hFFFFFFFA);

    drive(1'b1, MD_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0);
    wait_idle(1'b0, nb);
    chk("multu_hi", bus.hi, 32'h00000002);
    chk("multu_lo", bus.lo, 32'hFFFFFFFA);

    drive(1'b1, MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_idle(1'b0, nb);
    chk("div_cycles", 32'(nb), 32'd10);
    chk("div_lo", bus.lo, 32'hFFFFFFFD);
    chk("div_hi", bus.hi, 32'hFFFFFFFF);

    drive(1'b1, MD_DIVU, 32'd7, 32'd2, 1'b0);
    wait_idle(1'b0, nb);
    chk("divu_lo", bus.lo, 32'd3);
    chk("divu_hi", bus.hi, 32'd1);

    // DIV with MFLO held in D behind it
    drive(1'b1, MD_DIV, 32'd100, 32'd7, 1'b1);
    chk("stall_busy", 32'(bus.stall_d), 32'h1);
    wait_idle(1'b1, nb);
    chk("stall_cycles", 32'(nb), 32'd10);
    bus.e_md_valid = 1; bus.e_md_op = MD_MFLO; bus.d_is_md = 0;
    #1;
    chk("mflo_rdata", bus.md_rdata, 32'd14);
    chk("mflo_stall", 32'(bus.stall_d), 32'h0);
    @(posedge clk); #1;
    bus.e_md_valid = 0;

    // Divide by zero leaves HI/LO untouched
    drive(1'b1, MD_MTHI, 32'hAAAA0000, 0, 1'b0);
    drive(1'b1, MD_MTLO, 32'h0000BBBB, 0, 1'b0);
    drive(1'b1, MD_DIV, 32'd55, 32'd0, 1'b0);
    wait_idle(1'b0, nb);
    chk("dz_cycles", 32'(nb), 32'd10);
    chk("dz_hi", bus.hi, 32'hAAAA0000);
    chk("dz_lo", bus.lo, 32'h0000BBBB);

    // Asynchronous reset in the middle of a MULT
    drive(1'b1, MD_MULT, 32'd5, 32'd6, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset_n = 0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_hi", bus.hi, 32'h0);
    chk("abort_lo", bus.lo, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    repeat (7) drive(1'b0, MD_MFHI, 0, 0, 1'b0);
    chk("abort_nocommit_hi", bus.hi, 32'h0);
    chk("abort_nocommit_lo", bus.lo, 32'h0);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
